// File: rtl/audio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_pkg                                                                |
// | Shared I2S audio constants, receiver state encoding and word packing.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package audio_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int FRAME_BCK   = 64;
  localparam int WORD_BITS   = 2 * SAMPLE_BITS;

  typedef logic [SAMPLE_BITS-1:0] sample_t;
  typedef logic [WORD_BITS-1:0]   word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_L = 2'd1,
    ST_LEFT   = 2'd2,
    ST_RIGHT  = 2'd3
  } rx_state_e;

  // Left sample occupies the upper half, matching the transmitter layout.
  function automatic word_t pack_word(input sample_t left, input sample_t right);
    return {left, right};
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_receiver_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_receiver_if                                                          |
// | I2S pins plus the buffered valid/ready output stream of the receiver.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface i2s_receiver_if;
  import audio_pkg::*;

  logic  bck;
  logic  lrck;
  logic  sin;
  word_t out_data;
  logic  out_valid;
  logic  out_ready;

  modport master (
    output bck, lrck, sin, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  bck, lrck, sin, out_ready,
    output out_data, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/i2s_rx_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_rx_sync                                                              |
// | Two-flop synchronizers for bck/lrck/sin and a bck rising-edge detector.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module i2s_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic bck,
  input  logic lrck,
  input  logic sin,
  output logic bck_rise,
  output logic lrck_s,
  output logic sin_s
);

  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic       bck_hist_q, bck_hist_d;

  always_comb begin
    meta_d     = {bck, lrck, sin};
    sync_d     = meta_q;
    bck_hist_d = sync_q[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      bck_hist_q <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      bck_hist_q <= bck_hist_d;
    end
  end

  // lrck/sin share bck's pipeline depth so they are sampled at the same bck edge.
  assign bck_rise = sync_q[2] & ~bck_hist_q;
  assign lrck_s   = sync_q[1];
  assign sin_s    = sync_q[0];

endmodule
`default_nettype wire

// File: rtl/i2s_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_receiver                                                             |
// | I2S capture FSM with 22.05k decimation and a small output FIFO.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module i2s_receiver
  import audio_pkg::*;
#(
  parameter int I2S_DELAY  = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          in_clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          mode_22k,
  i2s_receiver_if.slave bus,
  output logic          overrun,
  output logic          frame_err,
  input  logic          clear_err
);

  localparam int           AW        = $clog2(FIFO_DEPTH);
  localparam int           CW        = $clog2(SAMPLE_BITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(SAMPLE_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_BITS - 1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  logic bck_rise, lrck_s, sin_s;

  i2s_rx_sync u_sync (
    .clk      (in_clk),
    .rst      (reset),
    .bck      (bus.bck),
    .lrck     (bus.lrck),
    .sin      (bus.sin),
    .bck_rise (bck_rise),
    .lrck_s   (lrck_s),
    .sin_s    (sin_s)
  );

  // With no delay the bit sampled on the framing bck is already the MSB.
  logic          msb_on_edge;
  logic [CW-1:0] start_cnt;

  if (I2S_DELAY == 0) begin : g_msb_on_edge
    assign msb_on_edge = 1'b1;
    assign start_cnt   = CW'(1);
  end else begin : g_msb_delayed
    assign msb_on_edge = 1'b0;
    assign start_cnt   = '0;
  end

  rx_state_e     state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  sample_t       left_q, left_d;
  sample_t       right_q, right_d;
  logic          lrck_prev_q, lrck_prev_d;
  logic          toggle_q, toggle_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  word_t         mem_q [FIFO_DEPTH];
  word_t         mem_d [FIFO_DEPTH];

  logic    lrck_fall, lrck_rise, can_shift;
  logic    word_done, ferr_set;
  logic    push, pop, full, wr_en, valid;
  sample_t left_shift, right_shift;
  word_t   push_word;

  assign left_shift  = {left_q[SAMPLE_BITS-2:0], sin_s};
  assign right_shift = {right_q[SAMPLE_BITS-2:0], sin_s};
  assign push_word   = pack_word(left_q, right_shift);
  assign lrck_fall   = bck_rise & lrck_prev_q & ~lrck_s;
  assign lrck_rise   = bck_rise & ~lrck_prev_q & lrck_s;
  assign can_shift   = bck_rise && (bit_cnt_q < CNT_FULL);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    left_d      = left_q;
    right_d     = right_q;
    toggle_d    = toggle_q;
    lrck_prev_d = bck_rise ? lrck_s : lrck_prev_q;
    word_done   = 1'b0;
    ferr_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        toggle_d = 1'b0;
        if (enable) state_d = ST_WAIT_L;
      end
      ST_WAIT_L: begin
        if (lrck_fall) begin
          state_d   = ST_LEFT;
          bit_cnt_d = start_cnt;
          if (msb_on_edge) left_d = left_shift;
        end
      end
      ST_LEFT: begin
        if (lrck_rise) begin
          bit_cnt_d = start_cnt;
          if (bit_cnt_q == CNT_FULL) begin
            state_d = ST_RIGHT;
            if (msb_on_edge) right_d = right_shift;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_WAIT_L;
          end
        end else if (can_shift) begin
          left_d    = left_shift;
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      ST_RIGHT: begin
        if (lrck_fall) begin
          // A short right half still leaves us framed on this new left half.
          ferr_set  = (bit_cnt_q != CNT_FULL);
          state_d   = ST_LEFT;
          bit_cnt_d = start_cnt;
          if (msb_on_edge) left_d = left_shift;
        end else if (can_shift) begin
          right_d   = right_shift;
          bit_cnt_d = bit_cnt_q + CW'(1);
          word_done = (bit_cnt_q == CNT_LAST);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (word_done && mode_22k) toggle_d = ~toggle_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      word_done = 1'b0;
      ferr_set  = 1'b0;
    end
  end

  assign valid = (wr_ptr_q != rd_ptr_q);
  assign pop   = valid & bus.out_ready;
  assign push  = word_done & (~mode_22k | ~toggle_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A same-cycle pop frees the head slot, so a push into a full FIFO still lands.
  assign wr_en = push & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_word;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    overrun_d   = clear_err ? 1'b0 : (overrun_q | (push & full & ~pop));
    frame_err_d = clear_err ? 1'b0 : (frame_err_q | ferr_set);
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      left_q      <= '0;
      right_q     <= '0;
      lrck_prev_q <= 1'b0;
      toggle_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      left_q      <= left_d;
      right_q     <= right_d;
      lrck_prev_q <= lrck_prev_d;
      toggle_q    <= toggle_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.out_valid = valid;
  assign overrun       = overrun_q;
  assign frame_err     = frame_err_q;

endmodule
`default_nettype wire

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Receives serial I2S audio (sound-in ADC path) and delivers 32-bit stereo words {L[15:0], R[15:0]} to the NeXT-side logic on the system clock.
- Mirror of the sound-out serializer:
  - 64 bck per frame; lrck low = left half, lrck high = right half.
  - 16 significant bits per half, MSB first; remaining bits ignored.
- bck, lrck and sin are asynchronous inputs, oversampled in the in_clk domain. Output is a 2-entry buffered valid/ready stream.

Parameters:
- I2S_DELAY, 0, 0 = MSB coincides with the lrck edge (matches our transmitter); 1 = standard I2S, MSB one bck after the edge.
- FIFO_DEPTH, 2, output buffer entries; power of 2, ≥2.

Ports:
- in_clk  in  1  system clock; must be ≥4× bck frequency.
- reset  in  1  synchronous, active-high.
- enable  in  1  receive enable (in_clk domain).
- mode_22k  in  1  1 = keep every second frame (22.05 kHz); 0 = every frame (44.1 kHz).
- bck  in  1  serial bit clock, async.
- lrck  in  1  word clock, async.
- sin  in  1  serial data, async; sampled on bck rising edge.
- out_data  out  32  {left, right} sample.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- overrun  out  1  sticky: a word was dropped because the FIFO was full.
- frame_err  out  1  sticky: a half-frame ended with fewer than 16 bits.
- clear_err  in  1  clears both sticky flags.

Behaviour:
- **Reset:** out_valid=0, out_data=0, overrun=0, frame_err=0. FSM=IDLE, FIFO empty, decimation toggle=0, synchronizer FFs=0.
- **Synchronizer:** bck, lrck, sin each pass through 2 FFs, then 1 history FF.
  - bck_rise = sync & ~hist. This is cycle D, 3 in_clk after the pin edge.
  - lrck is sampled only on bck_rise cycles. lrck_edge = a change versus the previous bck_rise sample.
- **FSM states:** IDLE, WAIT_L, LEFT, RIGHT.
  - IDLE: enable=1 → WAIT_L.
  - WAIT_L: lrck falling edge (1→0) at bck_rise → LEFT, bit_cnt=0. Capture starts per I2S_DELAY: same bck if 0, next bck if 1.
  - LEFT: shift sin into left reg while bit_cnt<16. Rising lrck edge → RIGHT.
    - If bit_cnt<16 at that edge: set frame_err, discard, go to WAIT_L.
  - RIGHT: shift into right reg while bit_cnt<16. On the bck_rise that shifts the 16th bit: word complete.
    - Later lrck falling edge → LEFT.
    - Falling edge with bit_cnt<16: frame_err, discard, stay framed in LEFT.
  - enable=0 in any state → IDLE at the next cycle. A partial word is discarded; FIFO contents are kept.
- **Word completion (cycle D of the 16th right bit):**
  - mode_22k=1: the decimation toggle flips on every completed word. The word is pushed only when the toggle was 0, so the first word after enable is kept. The toggle resets in IDLE.
  - Push writes at D+1; out_valid=1 from D+1 if the FIFO was empty.
  - FIFO full at push: the word is dropped and overrun=1. Existing entries are unchanged.
- **FIFO:**
  - Pop when out_valid & out_ready. Push and pop in the same cycle are both performed, including when full: the pop frees a slot, so there is no overrun.
  - out_data holds the head entry; it is stable while out_valid & ~out_ready.
- **Sticky flags:** clear_err has priority over a same-cycle set; that event is lost. reset clears both flags.
- **Extra bits:** bits 17..32 of each half are ignored. bit_cnt saturates at 16; it does not wrap.

Decomposition:
- Shared package (audio_pkg):
  - SAMPLE_BITS=16, FRAME_BCK=64.
  - State encoding for IDLE/WAIT_L/LEFT/RIGHT.
  - Word layout: left in [31:16], right in [15:0]. The transmitter uses the same layout.
- One sub-module, i2s_rx_sync: 2-FF synchronizers plus the bck-rise detector, outputting bck_rise, lrck_s, sin_s. The FIFO stays inline.

Test Plan:
- **Basic 44k:** enable=1, mode_22k=0, bck = in_clk/8; send L=0xD999, R=0x9991 (MSB at the lrck edge). Expect out_valid at D+1 after the 16th R bit and out_data=0xD9999991. Popping with out_ready=1 gives out_valid=0 next cycle.
- **Mid-frame enable:** enable asserted while lrck=1 mid-right-half. No word may be output until after the next lrck falling edge; the first word equals the next full frame sent.
- **22k decimation:** mode_22k=1; send frames 0x11112222, 0x33334444, 0x55556666, 0x77778888. Output exactly 0x11112222, then 0x55556666.
- **Overrun:** out_ready=0; send 3 frames A, B, C. Expect FIFO to hold A, B; overrun=1. Then out_ready=1 yields A, B only. clear_err → overrun=0.
- **Framing error:** lrck rises after 10 left bits. Expect frame_err=1 and no word output. The next clean frame 0x12345678 is output correctly.
- **Reset and I2S_DELAY:** assert reset mid-right-half; expect all outputs 0 and FIFO empty. Rerun the basic test with I2S_DELAY=1 and MSB delayed one bck; expect the same 0xD9999991.
